// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares the LSU load/store port between the core (m0) and a loader/debug master (m1).
// Round-robin arbitration by default; define ARB_FIXED_PRIO_EN to give m0 fixed priority.
module lsu_port_arbiter #(
   parameter int DM_ADDRESS = 10,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [DM_ADDRESS-1:0] m0_addr_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   input  logic [2:0]            m0_funct3_i,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [DM_ADDRESS-1:0] m1_addr_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic [2:0]            m1_funct3_i,
   output logic                  m0_gnt_o,
   output logic                  m1_gnt_o,
   output logic                  m0_rvalid_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [DM_ADDRESS-1:0] mem_a_o,
   output logic [DATA_W-1:0]     mem_wd_o,
   output logic [2:0]            mem_funct3_o,
   input  logic [DATA_W-1:0]     rd_i,
   output logic                  busy_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT > 0 ? RD_LAT - 1 : 0);
   state_t state, next_state;
   logic owner, cmd_we, win1, any_req;
   logic [1:0] cnt;
   assign any_req = m0_req_i | m1_req_i;
`ifdef ARB_FIXED_PRIO_EN
   assign win1 = m1_req_i & ~m0_req_i;
`else
   logic last;
   // on a tie the master that did not win last time goes first
   assign win1 = m1_req_i & (~m0_req_i | ~last);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) last <= 1'b1;
      else if ((state == ISSUE && cmd_we) || state == RESP) last <= owner;
`endif
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else state <= next_state;
   always_comb begin
      next_state  = state;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      m0_gnt_o    = 1'b0;
      m1_gnt_o    = 1'b0;
      m0_rvalid_o = 1'b0;
      m1_rvalid_o = 1'b0;
      case (state)
         IDLE: next_state = any_req ? ISSUE : IDLE;
         ISSUE: begin
            mem_read_o  = ~cmd_we;
            mem_write_o = cmd_we;
            m0_gnt_o    = ~owner;
            m1_gnt_o    = owner;
            next_state  = cmd_we ? IDLE : (RD_LAT == 0 ? RESP : WAIT);
         end
         WAIT: next_state = (cnt == 2'd0) ? RESP : WAIT;
         RESP: begin
            m0_rvalid_o = ~owner;
            m1_rvalid_o = owner;
            next_state  = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end
   assign busy_o = state != IDLE;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         owner        <= 1'b0;
         cmd_we       <= 1'b0;
         mem_a_o      <= '0;
         mem_wd_o     <= '0;
         mem_funct3_o <= '0;
         rdata_o      <= '0;
         cnt          <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            owner        <= win1;
            cmd_we       <= win1 ? m1_we_i : m0_we_i;
            mem_a_o      <= win1 ? m1_addr_i : m0_addr_i;
            mem_wd_o     <= win1 ? m1_wdata_i : m0_wdata_i;
            mem_funct3_o <= win1 ? m1_funct3_i : m0_funct3_i;
         end
         if (state == ISSUE) cnt <= CNT_INIT;
         else if (state == WAIT) cnt <= cnt - 2'd1;
         if ((state == ISSUE && !cmd_we && RD_LAT == 0) || (state == WAIT && cnt == 2'd0)) rdata_o <= rd_i;
      end
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: scoreboard bench; instance 0 has RD_LAT=1, instance 1 RD_LAT=0, instance 2 RD_LAT=3.
module tb_lsu_port_arbiter;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   typedef struct packed {logic [1:0] who; logic [31:0] data;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [9:0] m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0, rd;
   logic [2:0] m0_f3 = 0, m1_f3 = 0;
   logic [2:0] g0, g1, rv0, rv1, mr, mw, bsy;
   logic [31:0] rdat [3];
   logic [31:0] wd [3];
   logic [9:0] ma [3];
   logic [2:0] f3o [3];
   logic [1:0] gnt_q [$];
   exp_t exp_q [$];
   logic [1:0] eg;
   exp_t e;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_f(input logic [9:0] a);
      return a == 10'h200 ? 32'h1234_5678 : 32'hA500_0000 ^ {22'd0, a};
   endfunction
   assign rd = mem_f(ma[0]);
   for (genvar g = 0; g < 3; g++) begin : g_dut
      lsu_port_arbiter #(.DM_ADDRESS(10), .DATA_W(32), .RD_LAT(g == 0 ? 1 : g == 1 ? 0 : 3)) dut (
         .clk_i(clk), .rst_ni(rst_n),
         .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_funct3_i(m0_f3),
         .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_funct3_i(m1_f3),
         .m0_gnt_o(g0[g]), .m1_gnt_o(g1[g]), .m0_rvalid_o(rv0[g]), .m1_rvalid_o(rv1[g]),
         .rdata_o(rdat[g]), .mem_read_o(mr[g]), .mem_write_o(mw[g]), .mem_a_o(ma[g]),
         .mem_wd_o(wd[g]), .mem_funct3_o(f3o[g]), .rd_i(rd), .busy_o(bsy[g]));
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (g0[0] | g1[0]) begin
         eg = gnt_q.size() != 0 ? gnt_q.pop_front() : 2'b00;
         chk("gnt_owner", {30'd0, g1[0], g0[0]}, {30'd0, eg});
      end
      if (rv0[0] | rv1[0]) begin
         e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
         chk("rvalid_owner", {30'd0, rv1[0], rv0[0]}, {30'd0, e.who});
         chk("rdata", rdat[0], e.data);
      end
   end
   task automatic req_one(input logic m, input logic we, input logic [9:0] a, input logic [31:0] d, input logic [2:0] f3);
      int got = 0;
      if (m) begin
         m1_we = we; m1_addr = a; m1_wdata = d; m1_f3 = f3; m1_req = 1;
      end else begin
         m0_we = we; m0_addr = a; m0_wdata = d; m0_f3 = f3; m0_req = 1;
      end
      for (int i = 0; i < 40 && got == 0; i++) begin
         @(negedge clk);
         if (m ? g1[0] : g0[0]) got = 1;
      end
      if (m) m1_req = 0;
      else m0_req = 0;
      chk("gnt_seen", got, 1);
   endtask
   task automatic hold_both(input logic we, input logic [9:0] a0, input logic [9:0] a1, input int n);
      int got = 0;
      m0_we = we; m1_we = we; m0_addr = a0; m1_addr = a1;
      m0_wdata = 32'h0000_00AA; m1_wdata = 32'h0000_00BB; m0_f3 = 3'b010; m1_f3 = 3'b010;
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 100 && got < n; i++) begin
         @(negedge clk);
         if (g0[0] | g1[0]) got++;
      end
      m0_req = 0; m1_req = 0;
      chk("hold_gnt_count", got, n);
   endtask
   initial begin
      logic w;
      repeat (3) @(negedge clk);
      chk("rst_busy", bsy[0], 0);
      chk("rst_strobes", {mr[0], mw[0]}, 0);
      chk("rst_gnt_rv", {g0[0], g1[0], rv0[0], rv1[0]}, 0);
      chk("rst_mem_a", ma[0], 0);
      chk("rst_mem_wd", wd[0], 0);
      chk("rst_funct3", f3o[0], 0);
      chk("rst_rdata", rdat[0], 0);
      rst_n = 1;
      @(negedge clk);
      gnt_q.push_back(2'b01);
      req_one(0, 1, 10'h010, 32'hDEAD_BEEF, 3'b010);
      chk("st_write", mw[0], 1);
      chk("st_read", mr[0], 0);
      chk("st_addr", ma[0], 10'h010);
      chk("st_wdata", wd[0], 32'hDEAD_BEEF);
      chk("st_funct3", f3o[0], 3'b010);
      @(negedge clk);
      chk("st_idle", bsy[0], 0);
      chk("st_write_low", mw[0], 0);
      gnt_q.push_back(2'b10);
      exp_q.push_back('{2'b10, 32'h1234_5678});
      req_one(1, 0, 10'h200, 32'h0, 3'b010);
      chk("ld_read", mr[0], 1);
      chk("ld_addr", ma[0], 10'h200);
      @(negedge clk);
      chk("ld_wait_read_low", mr[0], 0);
      chk("ld_wait_busy", bsy[0], 1);
      chk("ld_wait_no_rv", rv1[0], 0);
      @(negedge clk);
      chk("ld_rvalid_m1", rv1[0], 1);
      chk("ld_rvalid_m0", rv0[0], 0);
      @(negedge clk);
      chk("ld_done_idle", bsy[0], 0);
      chk("ld_rdata_held", rdat[0], 32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         w = FIXED ? 1'b0 : i[0];
         gnt_q.push_back(w ? 2'b10 : 2'b01);
         exp_q.push_back('{w ? 2'b10 : 2'b01, mem_f(w ? 10'h3F8 : 10'h044)});
      end
      hold_both(0, 10'h044, 10'h3F8, 4);
      repeat (4) @(negedge clk);
      gnt_q.push_back(2'b01);
      req_one(0, 1, 10'h020, 32'h5555_0000, 3'b000);
      @(negedge clk);
      gnt_q.push_back(2'b10);
      req_one(1, 0, 10'h100, 32'h0, 3'b100);
      @(negedge clk);
      chk("mid_wait_busy", bsy[0], 1);
      #1 rst_n = 0;
      #1;
      chk("arst_busy", bsy[0], 0);
      chk("arst_strobes", {mr[0], mw[0], g0[0], g1[0], rv0[0], rv1[0]}, 0);
      chk("arst_mem_a", ma[0], 0);
      chk("arst_rdata", rdat[0], 0);
      @(negedge clk);
      rst_n = 1;
      repeat (4) @(negedge clk);
      chk("arst_no_load", rdat[0], 0);
      gnt_q.push_back(2'b01);
      gnt_q.push_back(FIXED ? 2'b01 : 2'b10);
      hold_both(1, 10'h030, 10'h034, 2);
      repeat (2) @(negedge clk);
      gnt_q.push_back(2'b10);
      req_one(1, 1, 10'h038, 32'h0000_0038, 3'b010);
      @(negedge clk);
      gnt_q.push_back(2'b01);
      exp_q.push_back('{2'b01, mem_f(10'h0C4)});
      req_one(0, 0, 10'h0C4, 32'h0, 3'b000);
      chk("lat0_strobe", mr[1], 1);
      chk("lat3_strobe", mr[2], 1);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("lat0_rvalid", rv0[1], k == 2);
         chk("lat3_rvalid", rv0[2], k == 5);
      end
      chk("lat0_rdata", rdat[1], mem_f(10'h0C4));
      chk("lat3_rdata", rdat[2], mem_f(10'h0C4));
      repeat (2) @(negedge clk);
      chk("gnt_q_drained", gnt_q.size(), 0);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
